// File: rtl/key_schedule_iter.sv
// key_schedule_iter
// Iterative AES key expansion for 128/192/256-bit keys. One schedule word is
// produced per clock into internal storage. Round keys are then served
// through a registered read port indexed by round number.
//
// Ports:
//   clk      - clock, rising edge
//   rst_n    - synchronous active-low reset
//   start    - request expansion, sampled only in IDLE
//   mode     - key size: 0 = AES-128, 1 = AES-192, 2 = AES-256, 3 = ignored
//   key      - cipher key, left-aligned (w0 = key[255:224])
//   busy     - expansion in progress
//   done     - one-cycle pulse when the schedule is complete
//   valid    - stored schedule is complete and consistent
//   nr       - round count of the captured mode (10/12/14), 0 after reset
//   rk_addr  - round-key index 0..nr
//   rk_data  - {w[4r], w[4r+1], w[4r+2], w[4r+3]}, one-cycle registered read
module key_schedule_iter #(
  parameter int unsigned WORD_LENGTH    = 32,
  parameter int unsigned Nb             = 4,
  parameter int unsigned MAX_KEY_LENGTH = 256,
  parameter int unsigned MAX_WORDS      = 60
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic [1:0]                  mode,
  input  logic [MAX_KEY_LENGTH-1:0]   key,
  output logic                        busy,
  output logic                        done,
  output logic                        valid,
  output logic [3:0]                  nr,
  input  logic [3:0]                  rk_addr,
  output logic [Nb*WORD_LENGTH-1:0]   rk_data
);

  localparam int unsigned AW  = $clog2(MAX_WORDS);
  localparam int unsigned NKW = MAX_KEY_LENGTH / WORD_LENGTH;
  localparam int unsigned KIW = $clog2(NKW);
  localparam int unsigned NBW = $clog2(Nb);

  typedef logic [WORD_LENGTH-1:0] word_t;
  typedef enum logic {IDLE, EXPAND} state_t;

  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic word_t sub_word(input word_t x);
    return {SBOX[x[31:24]], SBOX[x[23:16]], SBOX[x[15:8]], SBOX[x[7:0]]};
  endfunction

  // Control state
  state_t                                state_q, state_d;
  logic [AW-1:0]                         i_q, i_d;
  logic [2:0]                            phase_q, phase_d;
  logic [7:0]                            rcon_q, rcon_d;
  logic [3:0]                            nk_q, nk_d;
  logic [3:0]                            nr_q, nr_d;
  logic                                  busy_q, busy_d;
  logic                                  done_q, done_d;
  logic                                  valid_q, valid_d;
  logic [Nb-1:0][WORD_LENGTH-1:0]        rk_data_q, rk_data_d;

  // Schedule storage; contents are don't-care after reset, so no reset here
  word_t                                 sched_mem [MAX_WORDS];

  logic                                  capture;
  logic [3:0]                            nk_sel, nr_sel;
  logic [NKW-1:0][WORD_LENGTH-1:0]       key_words;
  word_t                                 prev_w, back_w, temp_w, new_w;
  logic [AW-1:0]                         last_i;
  logic [AW-1:0]                         rd_base;
  logic                                  rd_in_range;

  always_comb begin
    key_words = key;
    capture   = (state_q == IDLE) && start && (mode != 2'd3);
    case (mode)
      2'd0:    begin nk_sel = 4'd4; nr_sel = 4'd10; end
      2'd1:    begin nk_sel = 4'd6; nr_sel = 4'd12; end
      default: begin nk_sel = 4'd8; nr_sel = 4'd14; end
    endcase
  end

  // Expansion datapath: w[i] = w[i-Nk] ^ temp(w[i-1])
  always_comb begin
    prev_w = sched_mem[i_q - AW'(1)];
    back_w = sched_mem[i_q - AW'(nk_q)];
    if (phase_q == 3'd0) begin
      temp_w = sub_word({prev_w[23:0], prev_w[31:24]}) ^ {rcon_q, 24'h0};
    end else if (nk_q == 4'd8 && phase_q == 3'd4) begin
      temp_w = sub_word(prev_w);
    end else begin
      temp_w = prev_w;
    end
    new_w  = back_w ^ temp_w;
    // Final word index is Nb*(nr+1)-1
    last_i = AW'((32'(nr_q) + 1) * Nb - 1);
  end

  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    phase_d = phase_q;
    rcon_d  = rcon_q;
    nk_d    = nk_q;
    nr_d    = nr_q;
    busy_d  = busy_q;
    valid_d = valid_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (capture) begin
          state_d = EXPAND;
          nk_d    = nk_sel;
          nr_d    = nr_sel;
          i_d     = AW'(nk_sel);
          phase_d = '0;
          rcon_d  = 8'h01;
          busy_d  = 1'b1;
          valid_d = 1'b0;
        end
      end
      EXPAND: begin
        i_d     = i_q + AW'(1);
        // phase tracks i mod Nk by wrapping instead of dividing
        phase_d = ({1'b0, phase_q} == nk_q - 4'd1) ? '0 : phase_q + 3'd1;
        if (phase_q == 3'd0) begin
          rcon_d = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);
        end
        if (i_q == last_i) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          valid_d = 1'b1;
        end
      end
    endcase
  end

  // Registered read port
  always_comb begin
    rk_data_d   = '0;
    rd_base     = AW'(32'(rk_addr) * Nb);
    rd_in_range = (nr_q != 4'd0) && (rk_addr <= nr_q);
    if (rd_in_range) begin
      for (int unsigned j = 0; j < Nb; j++) begin
        rk_data_d[NBW'(Nb - 1 - j)] = sched_mem[rd_base + AW'(j)];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      i_q       <= '0;
      phase_q   <= '0;
      rcon_q    <= '0;
      nk_q      <= '0;
      nr_q      <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      valid_q   <= 1'b0;
      rk_data_q <= '0;
    end else begin
      state_q   <= state_d;
      i_q       <= i_d;
      phase_q   <= phase_d;
      rcon_q    <= rcon_d;
      nk_q      <= nk_d;
      nr_q      <= nr_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      valid_q   <= valid_d;
      rk_data_q <= rk_data_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (capture) begin
        for (int unsigned k = 0; k < NKW; k++) begin
          if (k < 32'(nk_sel)) begin
            sched_mem[AW'(k)] <= key_words[KIW'(NKW - 1 - k)];
          end
        end
      end else if (state_q == EXPAND) begin
        sched_mem[i_q] <= new_w;
      end
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign valid   = valid_q;
  assign nr      = nr_q;
  assign rk_data = rk_data_q;

endmodule

// File: tb/tb_key_schedule_iter.sv
// Testbench for key_schedule_iter: table of known FIPS-197 round keys read
// through a scoreboard queue, plus hand-written protocol/reset sequences.
module tb_key_schedule_iter;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [1:0]   mode;
  logic [255:0] key;
  logic         busy;
  logic         done;
  logic         valid;
  logic [3:0]   nr;
  logic [3:0]   rk_addr;
  logic [127:0] rk_data;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [1:0]   m;
    logic [3:0]   addr;
    logic [127:0] exp;
  } rd_vec_t;

  typedef struct {
    logic [3:0]   addr;
    logic [127:0] exp;
  } sb_t;

  rd_vec_t vec [15];
  sb_t     sb [$];

  localparam logic [255:0] KEY128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [255:0] KEY192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
  localparam logic [255:0] KEY256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

  key_schedule_iter #(
    .WORD_LENGTH(32),
    .Nb(4),
    .MAX_KEY_LENGTH(256),
    .MAX_WORDS(60)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .mode(mode),
    .key(key),
    .busy(busy),
    .done(done),
    .valid(valid),
    .nr(nr),
    .rk_addr(rk_addr),
    .rk_data(rk_data)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic pop_cmp();
    sb_t e;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check($sformatf("rk_data[%0d]", e.addr), rk_data, e.exp);
    end
  endtask

  // Stream every table address for mode m; each entry is compared one
  // cycle after its address was presented.
  task automatic read_mode(input logic [1:0] m);
    for (int v = 0; v < 15; v++) begin
      if (vec[v].m == m) begin
        @(negedge clk);
        pop_cmp();
        rk_addr = vec[v].addr;
        sb.push_back('{vec[v].addr, vec[v].exp});
      end
    end
    @(negedge clk);
    pop_cmp();
  endtask

  // Cycle n is the one closing at edge n; edge 0 samples start, so the
  // first negedge after it shows the cycle-1 values.
  task automatic run_expand(input logic [1:0] m, input logic [255:0] k,
                            input int repulse_at, input int exp_lat,
                            input logic [3:0] exp_nr);
    int   cyc;
    logic seen;
    @(negedge clk);
    mode  = m;
    key   = k;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc   = 1;
    check("busy_cycle1", 128'(busy), 128'(1'b1));
    check("valid_drop", 128'(valid), 128'(1'b0));
    seen = 1'b0;
    while (!seen && cyc < 100) begin
      if (done) begin
        seen = 1'b1;
      end else begin
        start = (cyc == repulse_at);
        @(negedge clk);
        cyc++;
      end
    end
    start = 1'b0;
    check("done_seen", 128'(seen), 128'(1'b1));
    check("done_latency", 128'(cyc), 128'(exp_lat));
    check("busy_at_done", 128'(busy), 128'(1'b0));
    check("valid_at_done", 128'(valid), 128'(1'b1));
    check("nr", 128'(nr), 128'(exp_nr));
    @(negedge clk);
    check("done_pulse_width", 128'(done), 128'(1'b0));
  endtask

  initial begin
    logic [127:0] rnd;
    int           cyc;
    logic         seen;

    vec[0]  = '{2'd0, 4'd0,  128'h2b7e151628aed2a6abf7158809cf4f3c};
    vec[1]  = '{2'd0, 4'd1,  128'ha0fafe1788542cb123a339392a6c7605};
    vec[2]  = '{2'd0, 4'd2,  128'hf2c295f27a96b9435935807a7359f67f};
    vec[3]  = '{2'd0, 4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
    vec[4]  = '{2'd0, 4'd11, 128'h0};
    vec[5]  = '{2'd0, 4'd15, 128'h0};
    vec[6]  = '{2'd1, 4'd0,  128'h8e73b0f7da0e6452c810f32b809079e5};
    vec[7]  = '{2'd1, 4'd1,  128'h62f8ead2522c6b7bfe0c91f72402f5a5};
    vec[8]  = '{2'd1, 4'd12, 128'he98ba06f448c773c8ecc720401002202};
    vec[9]  = '{2'd1, 4'd13, 128'h0};
    vec[10] = '{2'd2, 4'd0,  128'h603deb1015ca71be2b73aef0857d7781};
    vec[11] = '{2'd2, 4'd1,  128'h1f352c073b6108d72d9810a30914dff4};
    vec[12] = '{2'd2, 4'd2,  128'h9ba354118e6925afa51a8b5f2067fcde};
    vec[13] = '{2'd2, 4'd14, 128'hfe4890d1e6188d0b046df344706c631e};
    vec[14] = '{2'd2, 4'd15, 128'h0};

    // Reset held with start asserted
    rst_n   = 1'b0;
    start   = 1'b1;
    mode    = 2'd0;
    key     = KEY128;
    rk_addr = 4'd1;
    repeat (3) begin
      @(negedge clk);
      check("reset_busy", 128'(busy), 128'(1'b0));
    end
    check("reset_done", 128'(done), 128'(1'b0));
    check("reset_valid", 128'(valid), 128'(1'b0));
    check("reset_nr", 128'(nr), 128'(4'd0));
    check("reset_rk_data", rk_data, 128'h0);
    start = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_after_reset", 128'(busy), 128'(1'b0));

    // AES-128 with junk in ignored key bits and a start pulse mid-run
    rnd = {$urandom(), $urandom(), $urandom(), $urandom()};
    run_expand(2'd0, KEY128 | {128'h0, rnd}, 10, 41, 4'd10);
    read_mode(2'd0);

    // Illegal mode leaves everything alone
    @(negedge clk);
    mode  = 2'd3;
    key   = {$urandom(), $urandom(), $urandom(), $urandom(),
             $urandom(), $urandom(), $urandom(), $urandom()};
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) begin
      check("mode3_no_busy", 128'(busy), 128'(1'b0));
      @(negedge clk);
    end
    check("mode3_valid_kept", 128'(valid), 128'(1'b1));
    check("mode3_nr_kept", 128'(nr), 128'(4'd10));
    read_mode(2'd0);

    // AES-192 and AES-256
    rnd = {$urandom(), $urandom(), $urandom(), $urandom()};
    run_expand(2'd1, KEY192 | {192'h0, rnd[63:0]}, 0, 47, 4'd12);
    read_mode(2'd1);
    run_expand(2'd2, KEY256, 0, 53, 4'd14);
    read_mode(2'd2);

    // Reset at cycle 20 of an AES-256 run
    @(negedge clk);
    mode  = 2'd2;
    key   = KEY256;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc   = 1;
    while (cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_busy", 128'(busy), 128'(1'b0));
    check("midrst_valid", 128'(valid), 128'(1'b0));
    check("midrst_done", 128'(done), 128'(1'b0));
    check("midrst_nr", 128'(nr), 128'(4'd0));
    check("midrst_rk_data", rk_data, 128'h0);
    rst_n = 1'b1;
    seen  = 1'b0;
    repeat (60) begin
      @(negedge clk);
      if (done || busy) seen = 1'b1;
    end
    check("midrst_stays_idle", 128'(seen), 128'(1'b0));

    // Fresh AES-128 after the interrupted run
    run_expand(2'd0, KEY128, 0, 41, 4'd10);
    read_mode(2'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
